// File: rtl/ifu_fetch_stage.sv
// ifu_fetch_stage: PC register, instruction fetch and IF/ID pipeline register
// Ports:
//    clk, reset          clock, synchronous active-high reset
//    stall               hold pc_f and all D registers
//    redirect/_pc        take redirect_pc instead of pc_f+4 on advance
//    flush/_pc           squash D and load flush_pc (beats stall and redirect)
//    im_addr, im_rdata   instruction-memory address and combinational read data
//    pc_f, pc4_f         fetch PC and its sequential successor
//    instr_d, pc_d       decode-stage instruction and its PC
//    pc8_d               link value for jal/jalr
//    valid_d, adel_d     D holds a fetched instruction / came from an illegal address
//    fetch_cnt           instructions accepted into D since reset
module ifu_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter logic [31:0] IM_WORDS = 32'd4096,
   parameter logic [31:0] FLUSH_PC = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic [31:0] im_addr,
   input  logic [31:0] im_rdata,
   output logic [31:0] pc_f,
   output logic [31:0] pc4_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        valid_d,
   output logic        adel_d,
   output logic [31:0] fetch_cnt
);
   // 33-bit end address so a memory reaching the top of the address space does not wrap
   localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);
   logic legal;
   assign im_addr = pc_f;
   assign pc4_f   = pc_f + 32'd4;
   assign pc8_d   = pc_d + 32'd8;
   assign legal   = (pc_f[1:0] == 2'b00) && (pc_f >= IM_BASE) && ({1'b0, pc_f} < IM_END);
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f      <= RESET_PC;
         instr_d   <= '0;
         pc_d      <= '0;
         valid_d   <= 1'b0;
         adel_d    <= 1'b0;
         fetch_cnt <= '0;
      end else if (flush) begin
         pc_f    <= flush_pc;
         instr_d <= '0;
         pc_d    <= '0;
         valid_d <= 1'b0;
         adel_d  <= 1'b0;
      end else if (!stall) begin
         // the instruction fetched alongside a redirect still enters D as the delay slot
         pc_f      <= redirect ? redirect_pc : pc4_f;
         pc_d      <= pc_f;
         valid_d   <= 1'b1;
         fetch_cnt <= fetch_cnt + 32'd1;
         instr_d   <= legal ? im_rdata : '0;
         adel_d    <= !legal;
      end
   end
endmodule

// File: tb/tb_ifu_fetch_stage.sv
// tb_ifu_fetch_stage: directed self-checking bench for ifu_fetch_stage
module tb_ifu_fetch_stage;
   logic clk = 1'b0;
   logic reset, stall, redirect, flush;
   logic [31:0] redirect_pc, flush_pc;
   logic [31:0] im_addr, im_rdata, pc_f, pc4_f, instr_d, pc_d, pc8_d, fetch_cnt;
   logic valid_d, adel_d;
   logic [31:0] im_addr2, im_rdata2, pc_f2, pc4_f2, instr_d2, pc_d2, pc8_d2, fetch_cnt2;
   logic valid_d2, adel_d2;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // memory contents: each word is the bitwise inverse of its address
   assign im_rdata  = ~im_addr;
   assign im_rdata2 = ~im_addr2;

   ifu_fetch_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .flush(flush), .flush_pc(flush_pc),
      .im_addr(im_addr), .im_rdata(im_rdata), .pc_f(pc_f), .pc4_f(pc4_f),
      .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d), .valid_d(valid_d),
      .adel_d(adel_d), .fetch_cnt(fetch_cnt)
   );

   ifu_fetch_stage #(.IM_BASE(32'h0), .IM_WORDS(32'h4000_0000)) dut_wide (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .flush(flush), .flush_pc(flush_pc),
      .im_addr(im_addr2), .im_rdata(im_rdata2), .pc_f(pc_f2), .pc4_f(pc4_f2),
      .instr_d(instr_d2), .pc_d(pc_d2), .pc8_d(pc8_d2), .valid_d(valid_d2),
      .adel_d(adel_d2), .fetch_cnt(fetch_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; flush = 1'b0;
      redirect_pc = '0; flush_pc = '0;
      step();
      reset = 1'b0;
      chk("rst_pc_f", pc_f, 32'h3000);
      chk("rst_im_addr", im_addr, 32'h3000);
      chk("rst_pc4_f", pc4_f, 32'h3004);
      chk("rst_instr_d", instr_d, 32'h0);
      chk("rst_pc_d", pc_d, 32'h0);
      chk("rst_pc8_d", pc8_d, 32'h8);
      chk("rst_valid_d", 32'(valid_d), 32'h0);
      chk("rst_adel_d", 32'(adel_d), 32'h0);
      chk("rst_fetch_cnt", fetch_cnt, 32'h0);

      step();
      chk("seq1_pc_f", pc_f, 32'h3004);
      chk("seq1_instr_d", instr_d, ~32'h3000);
      step();
      chk("seq2_pc_f", pc_f, 32'h3008);
      step();
      chk("seq3_pc_f", pc_f, 32'h300C);
      chk("seq3_pc_d", pc_d, 32'h3008);
      chk("seq3_valid_d", 32'(valid_d), 32'h1);
      chk("seq3_fetch_cnt", fetch_cnt, 32'd3);
      chk("seq3_pc8_d", pc8_d, 32'h3010);

      redirect = 1'b1; redirect_pc = 32'h3100;
      step();
      chk("redir_pc_f", pc_f, 32'h3100);
      chk("redir_slot_instr", instr_d, ~32'h300C);
      chk("redir_slot_pc_d", pc_d, 32'h300C);
      chk("redir_slot_valid", 32'(valid_d), 32'h1);

      stall = 1'b1; redirect_pc = 32'h3200;
      step();
      chk("stall1_pc_f", pc_f, 32'h3100);
      chk("stall1_instr_d", instr_d, ~32'h300C);
      chk("stall1_fetch_cnt", fetch_cnt, 32'd4);
      step();
      chk("stall2_pc_f", pc_f, 32'h3100);
      chk("stall2_fetch_cnt", fetch_cnt, 32'd4);
      stall = 1'b0;
      step();
      chk("unstall_pc_f", pc_f, 32'h3200);
      chk("unstall_instr_d", instr_d, ~32'h3100);
      chk("unstall_fetch_cnt", fetch_cnt, 32'd5);

      stall = 1'b1; flush = 1'b1; flush_pc = 32'h4180;
      step();
      chk("flush_pc_f", pc_f, 32'h4180);
      chk("flush_valid_d", 32'(valid_d), 32'h0);
      chk("flush_instr_d", instr_d, 32'h0);
      chk("flush_pc_d", pc_d, 32'h0);
      chk("flush_fetch_cnt", fetch_cnt, 32'd5);

      stall = 1'b0; flush = 1'b0; redirect_pc = 32'h3002;
      step();
      chk("mis_pc_f", pc_f, 32'h3002);
      chk("post_flush_instr", instr_d, ~32'h4180);
      chk("post_flush_adel", 32'(adel_d), 32'h0);
      redirect_pc = 32'h7000;
      step();
      chk("mis_adel_d", 32'(adel_d), 32'h1);
      chk("mis_instr_d", instr_d, 32'h0);
      chk("mis_pc_d", pc_d, 32'h3002);
      chk("mis_valid_d", 32'(valid_d), 32'h1);
      redirect_pc = 32'h6FFC;
      step();
      chk("oor_adel_d", 32'(adel_d), 32'h1);
      chk("oor_instr_d", instr_d, 32'h0);
      chk("oor_pc_d", pc_d, 32'h7000);
      chk("oor_fetch_cnt", fetch_cnt, 32'd8);
      redirect_pc = 32'h2FFC;
      step();
      chk("top_word_adel", 32'(adel_d), 32'h0);
      chk("top_word_instr", instr_d, ~32'h6FFC);
      redirect = 1'b0;
      step();
      chk("below_base_adel", 32'(adel_d), 32'h1);
      chk("below_base_pc_d", pc_d, 32'h2FFC);

      stall = 1'b1; flush = 1'b1; reset = 1'b1;
      step();
      chk("rst_win_pc_f", pc_f, 32'h3000);
      chk("rst_win_fetch_cnt", fetch_cnt, 32'h0);
      chk("rst_win_valid_d", 32'(valid_d), 32'h0);

      reset = 1'b0; stall = 1'b0; flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
      step();
      chk("wrap_pc_f", pc_f2, 32'hFFFF_FFFC);
      chk("wrap_pc4_f", pc4_f2, 32'h0);
      flush = 1'b0;
      step();
      chk("wrap_next_pc_f", pc_f2, 32'h0);
      chk("wrap_pc_d", pc_d2, 32'hFFFF_FFFC);
      chk("wrap_pc8_d", pc8_d2, 32'h4);
      chk("wrap_adel_d", 32'(adel_d2), 32'h0);
      chk("wrap_instr_d", instr_d2, 32'h3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
